noise_video_gen: RTL and testbench
==================================

// Module: noise_video_gen
// PURPOSE
//  Pixel-clock-enable, raster timing and LFSR noise generator for the core's video path.
//  Sits between clk_sys and the emu output stage, which colours/masks video onto VGA_R/G/B.
//  Produces 15 kHz NTSC/PAL rasters, or 31 kHz line-doubled rasters when scandouble=1.
//  Runs at a 20.0 MHz clk; the Y/C colourburst constants rely on this rate.
// PARAMETERS
//  H_ACTIVE   256        visible pixels per line
//  H_TOTAL    320        pixel ticks per line
//  HS_START   272        first HSync pixel
//  HS_END     296        first pixel after HSync
//  V_ACTIVE   240        visible lines (15 kHz line units)
//  V_NTSC     262        lines per NTSC frame
//  V_PAL      312        lines per PAL frame
//  VS_START   244        first VSync line
//  VS_END     247        first line after VSync
//  LFSR_SEED  16'hACE1   LFSR reset value; must be nonzero
// PORTS
//  clk         in   1  system clock (clk_sys, 20 MHz)
//  reset       in   1  synchronous, active-high
//  pal         in   1  1=PAL line count, 0=NTSC
//  scandouble  in   1  1=31 kHz line-doubled output
//  ce_pix      out  1  pixel clock enable, one clk wide
//  HBlank      out  1  horizontal blank
//  HSync       out  1  horizontal sync, active high
//  VBlank      out  1  vertical blank
//  VSync       out  1  vertical sync, active high
//  video       out  8  luma; 0 while blanked
// BEHAVIOUR
//  Reset values:
//   - div=0, ce_pix=0, HSync=0, VSync=0, video=0, lfsr=LFSR_SEED
//   - HBlank=1, VBlank=1
//   - hcnt=H_TOTAL-1, vcnt=vtot-1, so the first ce lands on pixel (0,0)
//   - mode latch {pal_l,sd_l} <= {pal,scandouble}
//  Clock enable:
//   - DIV = sd_l ? 2 : 4; div counts 0..DIV-1 and wraps.
//   - ce_pix is registered, high for the one clk where div==DIV-1.
//   - First ce_pix is on the 4th clk after reset release (2nd when scandouble).
//  Counters and outputs, updated only on clk edges where ce_pix=1:
//   - hcnt advances modulo H_TOTAL.
//   - On hcnt wrap, vcnt advances modulo vtot.
//   - vtot = (pal_l ? V_PAL : V_NTSC) << sd_l.
//   - V thresholds compare against vcnt >> sd_l, so every line is emitted twice when scandoubled.
//   - The mode latch reloads only on the vcnt wrap to 0 (frame start); a mid-frame pal or
//     scandouble change never alters the frame in progress.
//   - All outputs are registered from the new (hcnt,vcnt).
//   - Outputs hold between ce pulses and change on the clk edge where ce_pix=1.
//  Decode (v = vcnt >> sd_l):
//   - HBlank = hcnt >= H_ACTIVE
//   - HSync  = HS_START <= hcnt < HS_END
//   - VBlank = v >= V_ACTIVE
//   - VSync  = VS_START <= v < VS_END, asserted for whole lines
//  LFSR:
//   - 16-bit Fibonacci, x^16+x^14+x^13+x^11+1.
//   - next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}
//   - On a ce with the new position active: video <= lfsr[7:0], lfsr <= next.
//   - Blanked positions: video <= 0 and lfsr holds.
//  Reset asserted mid-frame: every register returns to its reset value on that edge.
//   No partial line is emitted; the frame restarts at (0,0) after release.
//  Any active/sync window maps to a 1-bit compare; arithmetic needs no widening beyond
//   hcnt[8:0] and vcnt[9:0].
// TESTING
//  1. Release reset, pal=0, sd=0:
//     ce_pix at clk 4, 8, 12...; first pixel video=8'hE1, second pixel 8'hC3.
//  2. NTSC 15 kHz:
//     HSync rising-edge period = 1280 clk; HSync high 96 clk.
//     VSync rising-edge period = 335360 clk; VSync high 3*1280 clk.
//  3. pal=1:
//     VSync rising-edge period = 399360 clk; VBlank high 72 lines/frame.
//  4. scandouble=1, pal=0:
//     ce_pix every 2 clk; HSync period = 640 clk.
//     Frame = 524 lines = 335360 clk; VSync spans 6 output lines.
//  5. Toggle pal at line 100:
//     the current frame still ends after 262 lines; the next frame is 312 lines.
//  6. Assert reset for 1 clk mid-line:
//     next clk HBlank=VBlank=1, video=0, lfsr=ACE1; first pixel after release =8'hE1.
//     Also confirm video=0 whenever HBlank|VBlank.

Source files
------------

// File: rtl/noise_video_gen_if.sv
// Video timing bundle between the noise generator and the output stage.
// The generator side drives timing/luma and samples the mode inputs.
interface noise_video_gen_if;
  logic       pal;
  logic       scandouble;
  logic       ce_pix;
  logic       HBlank;
  logic       HSync;
  logic       VBlank;
  logic       VSync;
  logic [7:0] video;

  modport master (
    input  pal,
    input  scandouble,
    output ce_pix,
    output HBlank,
    output HSync,
    output VBlank,
    output VSync,
    output video
  );

  modport slave (
    output pal,
    output scandouble,
    input  ce_pix,
    input  HBlank,
    input  HSync,
    input  VBlank,
    input  VSync,
    input  video
  );
endinterface

// File: rtl/noise_video_gen.sv
// Pixel clock enable, 15/31 kHz raster timing and LFSR luma noise.
// The mode (pal/scandouble) is latched at reset and at every frame start.
module noise_video_gen #(
  parameter int          H_ACTIVE  = 256,
  parameter int          H_TOTAL   = 320,
  parameter int          HS_START  = 272,
  parameter int          HS_END    = 296,
  parameter int          V_ACTIVE  = 240,
  parameter int          V_NTSC    = 262,
  parameter int          V_PAL     = 312,
  parameter int          VS_START  = 244,
  parameter int          VS_END    = 247,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  noise_video_gen_if.master vid
);
  localparam logic [8:0] H_ACT_W   = 9'(H_ACTIVE);
  localparam logic [8:0] H_LAST_W  = 9'(H_TOTAL - 1);
  localparam logic [8:0] HS_BEG_W  = 9'(HS_START);
  localparam logic [8:0] HS_END_W  = 9'(HS_END);
  localparam logic [9:0] V_ACT_W   = 10'(V_ACTIVE);
  localparam logic [9:0] V_NTSC_W  = 10'(V_NTSC);
  localparam logic [9:0] V_PAL_W   = 10'(V_PAL);
  localparam logic [9:0] VS_BEG_W  = 10'(VS_START);
  localparam logic [9:0] VS_END_W  = 10'(VS_END);

  // Frame length in counter lines; doubled when every line is emitted twice.
  function automatic logic [9:0] vtot_f(input logic pal_m, input logic sd_m);
    logic [9:0] base;
    base = pal_m ? V_PAL_W : V_NTSC_W;
    return sd_m ? {base[8:0], 1'b0} : base;
  endfunction

  function automatic logic [15:0] lfsr_next_f(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [1:0]  div_q, div_d;
  logic        ce_q, ce_d;
  logic [8:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        pal_l_q, pal_l_d;
  logic        sd_l_q, sd_l_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        hblank_q, hblank_d;
  logic        hsync_q, hsync_d;
  logic        vblank_q, vblank_d;
  logic        vsync_q, vsync_d;
  logic [7:0]  video_q, video_d;
  logic [1:0]  div_max;
  logic [9:0]  vline;
  logic        active;

  always_comb begin
    div_max  = sd_l_q ? 2'd1 : 2'd3;
    ce_d     = (div_q >= div_max);
    div_d    = ce_d ? 2'd0 : div_q + 2'd1;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    pal_l_d  = pal_l_q;
    sd_l_d   = sd_l_q;
    lfsr_d   = lfsr_q;
    hblank_d = hblank_q;
    hsync_d  = hsync_q;
    vblank_d = vblank_q;
    vsync_d  = vsync_q;
    video_d  = video_q;
    vline    = '0;
    active   = 1'b0;
    if (ce_q) begin
      hcnt_d = (hcnt_q == H_LAST_W) ? 9'd0 : hcnt_q + 9'd1;
      if (hcnt_q == H_LAST_W) begin
        if (vcnt_q == vtot_f(pal_l_q, sd_l_q) - 10'd1) begin
          vcnt_d  = 10'd0;
          pal_l_d = vid.pal;
          sd_l_d  = vid.scandouble;
        end else begin
          vcnt_d = vcnt_q + 10'd1;
        end
      end
      // At frame start vline is 0 whichever latch value is used.
      vline    = sd_l_q ? {1'b0, vcnt_d[9:1]} : vcnt_d;
      hblank_d = (hcnt_d >= H_ACT_W);
      hsync_d  = (hcnt_d >= HS_BEG_W) && (hcnt_d < HS_END_W);
      vblank_d = (vline >= V_ACT_W);
      vsync_d  = (vline >= VS_BEG_W) && (vline < VS_END_W);
      active   = !hblank_d && !vblank_d;
      video_d  = active ? lfsr_q[7:0] : 8'd0;
      if (active) begin
        lfsr_d = lfsr_next_f(lfsr_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= 2'd0;
      ce_q     <= 1'b0;
      hcnt_q   <= H_LAST_W;
      vcnt_q   <= vtot_f(vid.pal, vid.scandouble) - 10'd1;
      pal_l_q  <= vid.pal;
      sd_l_q   <= vid.scandouble;
      lfsr_q   <= LFSR_SEED;
      hblank_q <= 1'b1;
      hsync_q  <= 1'b0;
      vblank_q <= 1'b1;
      vsync_q  <= 1'b0;
      video_q  <= 8'd0;
    end else begin
      div_q    <= div_d;
      ce_q     <= ce_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      pal_l_q  <= pal_l_d;
      sd_l_q   <= sd_l_d;
      lfsr_q   <= lfsr_d;
      hblank_q <= hblank_d;
      hsync_q  <= hsync_d;
      vblank_q <= vblank_d;
      vsync_q  <= vsync_d;
      video_q  <= video_d;
    end
  end

  assign vid.ce_pix = ce_q;
  assign vid.HBlank = hblank_q;
  assign vid.HSync  = hsync_q;
  assign vid.VBlank = vblank_q;
  assign vid.VSync  = vsync_q;
  assign vid.video  = video_q;
endmodule

// File: tb/tb_noise_video_gen.sv
// Bench for noise_video_gen on a shrunken raster so whole frames fit in a short run.
// A pixel-index reference model is checked every clk; sequences cover timing corners.
module tb_noise_video_gen;
  localparam int HA = 16, HT = 24, HSS = 18, HSE = 21;
  localparam int VA = 10, VN = 14, VP = 17, VSS = 11, VSE = 13;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  noise_video_gen_if vif();

  noise_video_gen #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .HS_START(HSS), .HS_END(HSE),
    .V_ACTIVE(VA), .V_NTSC(VN), .V_PAL(VP), .VS_START(VSS), .VS_END(VSE),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vid(vif)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int errors = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    errors++;
    $display("FAIL %s actual=timeout expected=event at cycle %0d", name, cyc);
  endtask

  // Reference model: frame position as a flat pixel index, mode fixed per frame.
  int m_cnt, m_div, m_pos, m_lines, m_sd;
  bit m_ce, e_hb, e_hs, e_vb, e_vs;
  logic [15:0] m_lfsr;
  logic [7:0]  e_video;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return (s << 1) | 16'(fb);
  endfunction

  task automatic load_mode();
    m_sd    = int'(vif.scandouble);
    m_div   = m_sd ? 2 : 4;
    m_lines = (vif.pal ? VP : VN) << m_sd;
  endtask

  task automatic model_step();
    int h, v;
    if (reset) begin
      load_mode();
      m_cnt = 0; m_ce = 0; m_pos = HT * m_lines - 1; m_lfsr = SEED;
      e_video = 0; e_hb = 1; e_vb = 1; e_hs = 0; e_vs = 0;
    end else begin
      if (m_ce) begin
        m_pos++;
        if (m_pos == HT * m_lines) begin
          m_pos = 0;
          load_mode();
        end
        h = m_pos % HT;
        v = (m_pos / HT) >> m_sd;
        e_hb = (h >= HA);
        e_hs = (h >= HSS) && (h < HSE);
        e_vb = (v >= VA);
        e_vs = (v >= VSS) && (v < VSE);
        if (!e_hb && !e_vb) begin
          e_video = m_lfsr[7:0];
          m_lfsr  = lfsr_step(m_lfsr);
        end else begin
          e_video = 0;
        end
      end
      m_cnt++;
      m_ce = (m_cnt >= m_div);
      if (m_ce) m_cnt = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      chk("outputs{ce,hb,hs,vb,vs,video}",
          32'({vif.ce_pix, vif.HBlank, vif.HSync, vif.VBlank, vif.VSync, vif.video}),
          32'({m_ce, e_hb, e_hs, e_vb, e_vs, e_video}));
      if (vif.HBlank || vif.VBlank) chk("blank_video", 32'(vif.video), 32'd0);
    end
  end

  typedef struct {
    bit pal;
    bit sd;
    int hs_per;
    int hs_hi;
    int vs_per;
    int vs_hi;
    int vb_clk;
  } vec_t;
  vec_t vecs[4];

  task automatic check_reset_values(input string tag);
    chk({tag, "_reset_ce"}, 32'(vif.ce_pix), 32'd0);
    chk({tag, "_reset_blank"}, 32'({vif.HBlank, vif.VBlank}), 32'b11);
    chk({tag, "_reset_sync"}, 32'({vif.HSync, vif.VSync}), 32'b00);
    chk({tag, "_reset_video"}, 32'(vif.video), 32'd0);
  endtask

  // Called right after reset drops, with scandouble=0.
  task automatic check_release(input string tag);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk({tag, "_ce"}, 32'(vif.ce_pix), 32'((k % 4) == 0));
      if (k == 5) chk({tag, "_pixel0"}, 32'(vif.video), 32'h00E1);
      if (k == 9) chk({tag, "_pixel1"}, 32'(vif.video), 32'h00C3);
    end
    $display("[TB] %s release sequence checked", tag);
  endtask

  task automatic measure(input vec_t t, input int idx);
    int rises = 0, t0 = 0, last_hs = -1;
    int hs_per = 0, hs_hi = 0, vs_hi = 0, vb = 0, vs_per = 0;
    bit phs, pvs, done = 0;
    vif.pal = t.pal;
    vif.scandouble = t.sd;
    phs = vif.HSync;
    pvs = vif.VSync;
    for (int c = 0; c < 6 * HT * VP * 4 && !done; c++) begin
      @(negedge clk);
      if (vif.VSync && !pvs) begin
        rises++;
        if (rises == 2) t0 = c;
        if (rises == 3) begin
          vs_per = c - t0;
          done = 1;
        end
      end
      if (rises == 2 && !done) begin
        if (vif.HSync && !phs) begin
          if (last_hs >= 0) hs_per = c - last_hs;
          last_hs = c;
        end
        hs_hi += int'(vif.HSync);
        vs_hi += int'(vif.VSync);
        vb    += int'(vif.VBlank);
      end
      phs = vif.HSync;
      pvs = vif.VSync;
    end
    if (!done) begin
      timeout($sformatf("vec%0d_vsync", idx));
    end else begin
      chk($sformatf("vec%0d_hs_period", idx), 32'(hs_per), 32'(t.hs_per));
      chk($sformatf("vec%0d_hs_high", idx), 32'(hs_hi), 32'(t.hs_hi));
      chk($sformatf("vec%0d_vs_period", idx), 32'(vs_per), 32'(t.vs_per));
      chk($sformatf("vec%0d_vs_high", idx), 32'(vs_hi), 32'(t.vs_hi));
      chk($sformatf("vec%0d_vblank_clk", idx), 32'(vb), 32'(t.vb_clk));
    end
    $display("[TB] vec%0d pal=%0d sd=%0d hs_per=%0d hs_hi=%0d vs_per=%0d vs_hi=%0d vb=%0d",
             idx, t.pal, t.sd, hs_per, hs_hi, vs_per, vs_hi, vb);
  endtask

  task automatic wait_vb_fall(input string name, output int t);
    bit prev;
    bit seen = 0;
    t = 0;
    prev = vif.VBlank;
    for (int c = 0; c < 2 * HT * VP * 4 && !seen; c++) begin
      @(negedge clk);
      if (prev && !vif.VBlank) begin
        seen = 1;
        t = cyc;
      end
      prev = vif.VBlank;
    end
    if (!seen) timeout(name);
  endtask

  initial begin
    int tb, tc, td, tmp, n;
    // Expected raster figures: pixel period 4 clk (2 when scandoubled), 24 pixels/line.
    vecs[0] = '{0, 0, 96, 168, 1344, 192, 384};
    vecs[1] = '{1, 0, 96, 204, 1632, 192, 672};
    vecs[2] = '{0, 1, 48, 168, 1344, 192, 384};
    vecs[3] = '{1, 1, 48, 204, 1632, 192, 672};

    vif.pal = 1'b0;
    vif.scandouble = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    check_reset_values("init");
    reset = 1'b0;
    check_release("init");

    for (int i = 0; i < 4; i++) measure(vecs[i], i);

    // Mode change mid-frame must only take effect at the next frame start.
    vif.pal = 1'b0;
    vif.scandouble = 1'b0;
    wait_vb_fall("pal_sync0", tmp);
    wait_vb_fall("pal_sync1", tmp);
    wait_vb_fall("pal_frame_b", tb);
    repeat (5 * HT * 4) @(negedge clk);
    vif.pal = 1'b1;
    wait_vb_fall("pal_frame_c", tc);
    wait_vb_fall("pal_frame_d", td);
    chk("pal_toggle_current_frame", 32'(tc - tb), 32'(HT * VN * 4));
    chk("pal_toggle_next_frame", 32'(td - tc), 32'(HT * VP * 4));
    $display("[TB] pal toggle frames: %0d then %0d clk", tc - tb, td - tc);

    // One-clk reset in the middle of a line.
    vif.pal = 1'b0;
    vif.scandouble = 1'b0;
    repeat (HT * 4 + 37) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midline");
    reset = 1'b0;
    check_release("midline");

    for (int it = 0; it < 16; it++) begin
      vif.pal = 1'($urandom_range(0, 1));
      vif.scandouble = 1'($urandom_range(0, 1));
      n = $urandom_range(200, 1500);
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        reset = ($urandom_range(0, 599) == 0);
      end
      reset = 1'b0;
      $display("[TB] random burst %0d pal=%0d sd=%0d cycles=%0d", it, vif.pal, vif.scandouble, n);
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
